// File: rtl/dm_pkg.sv
// Shared encodings and helpers for the sized data memory.
// Build option: DM_TRACE_EN enables a store trace in dm_sized.
package dm_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [1:0] {
        CLEAR,
        IDLE,
        WAIT
    } state_t;

    function automatic logic dm_illegal(
        input logic [1:0] size,
        input logic [1:0] off,
        input logic       oor
    );
        logic bad;
        bad = oor;
        case (size)
            SZ_B:    bad = bad;
            SZ_H:    bad = bad | off[0];
            SZ_W:    bad = bad | (|off);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dm_lane_fmt.sv
// Byte-lane merge for stores and extract/extend for loads.
// Little-endian lanes; purely combinational.
module dm_lane_fmt
    import dm_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  logic [1:0]  st_off,
    input  logic [1:0]  st_size,
    output logic [31:0] new_word,
    input  logic [31:0] rd_word,
    input  logic [1:0]  ld_off,
    input  logic [1:0]  ld_size,
    input  logic        ld_uns,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // store: overwrite only the addressed lanes of the old word
    always_comb begin
        new_word = old_word;
        case (st_size)
            SZ_B:    new_word[{st_off, 3'b000} +: 8] = wdata[7:0];
            SZ_H:    new_word[{st_off[1], 4'b0000} +: 16] = wdata[15:0];
            default: new_word = wdata;
        endcase
    end

    // load: pick the addressed lanes and sign/zero extend
    always_comb begin
        ld_byte = rd_word[{ld_off, 3'b000} +: 8];
        ld_half = rd_word[{ld_off[1], 4'b0000} +: 16];
        case (ld_size)
            SZ_B:    ld_data = {{24{~ld_uns & ld_byte[7]}}, ld_byte};
            SZ_H:    ld_data = {{16{~ld_uns & ld_half[15]}}, ld_half};
            default: ld_data = rd_word;
        endcase
    end

endmodule

// File: rtl/dm_sized.sv
// Sized data memory: clear-after-reset, sub-word access, req/ready/rvalid.
// Build option: DM_TRACE_EN prints every committed store.
module dm_sized
    import dm_pkg::*;
#(
    parameter int WORDS    = 1024,
    parameter int READ_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] pc,
    output logic        ready,
    output logic        rvalid,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int AW = $clog2(WORDS);

    state_t        state, state_n;
    logic [AW-1:0] clr_idx;
    logic [2:0]    cnt;
    logic [AW-1:0] l_idx;
    logic [1:0]    l_off, l_size;
    logic          l_uns;
    logic [31:0]   mem [WORDS];

    logic [AW-1:0] idx, rd_idx;
    logic [1:0]    ld_off, ld_size;
    logic          ld_uns;
    logic          accept, bad, do_store, do_load, done;
    logic [31:0]   st_word, ld_data;

    assign ready    = (state == IDLE);
    assign idx      = addr[AW+1:2];
    assign accept   = req && ready;
    assign bad      = dm_illegal(size, addr[1:0], |addr[31:AW+2]);
    assign do_store = accept && we && !bad;
    assign do_load  = accept && !we && !bad;
    // single-cycle latency reads straight at the acceptance edge
    assign done     = (state == WAIT && cnt == 3'd1)
                   || (READ_LAT == 1 && do_load);

    assign rd_idx  = (state == WAIT) ? l_idx  : idx;
    assign ld_off  = (state == WAIT) ? l_off  : addr[1:0];
    assign ld_size = (state == WAIT) ? l_size : size;
    assign ld_uns  = (state == WAIT) ? l_uns  : uns;

    dm_lane_fmt u_fmt (
        .old_word (mem[idx]),
        .wdata    (wdata),
        .st_off   (addr[1:0]),
        .st_size  (size),
        .new_word (st_word),
        .rd_word  (mem[rd_idx]),
        .ld_off   (ld_off),
        .ld_size  (ld_size),
        .ld_uns   (ld_uns),
        .ld_data  (ld_data)
    );

    // state register
    always_ff @(posedge clk) begin
        if (!reset) state <= CLEAR;
        else        state <= state_n;
    end

    // next-state: clear sweep, then idle/wait around loads
    always_comb begin
        state_n = state;
        unique case (state)
            CLEAR: if (clr_idx == AW'(WORDS - 1)) state_n = IDLE;
            IDLE:  if (do_load && READ_LAT > 1) state_n = WAIT;
            WAIT:  if (cnt == 3'd1) state_n = IDLE;
            default: state_n = CLEAR;
        endcase
    end

    // clear index and read-latency counter
    always_ff @(posedge clk) begin
        if (!reset) begin
            clr_idx <= '0;
            cnt     <= '0;
        end else begin
            if (state == CLEAR) clr_idx <= clr_idx + AW'(1);
            if (do_load)             cnt <= 3'(READ_LAT - 1);
            else if (state == WAIT)  cnt <= cnt - 3'd1;
        end
    end

    // capture load attributes for the wait period
    always_ff @(posedge clk) begin
        if (do_load) begin
            l_idx  <= idx;
            l_off  <= addr[1:0];
            l_size <= size;
            l_uns  <= uns;
        end
    end

    // array writes: zero sweep after reset, then committed stores
    always_ff @(posedge clk) begin
        if (reset) begin
            if (state == CLEAR) mem[clr_idx] <= '0;
            else if (do_store)  mem[idx] <= st_word;
        end
    end

    // response pulses and held read data
    always_ff @(posedge clk) begin
        if (!reset) begin
            rvalid <= 1'b0;
            err    <= 1'b0;
            rdata  <= '0;
        end else begin
            rvalid <= 1'b0;
            err    <= 1'b0;
            if (accept && bad) begin
                err <= 1'b1;
                if (!we) begin
                    rvalid <= 1'b1;
                    rdata  <= '0;
                end
            end
            if (done) begin
                rvalid <= 1'b1;
                rdata  <= ld_data;
            end
        end
    end

`ifdef DM_TRACE_EN
    // store trace: pc, word address, merged word
    always_ff @(posedge clk) begin
        if (reset && do_store)
            $display("@%h: *%h <= %h", pc, {addr[31:2], 2'b00}, st_word);
    end
`else
    logic unused_pc;
    assign unused_pc = ^pc;
`endif

endmodule

// File: tb/tb_dm_sized.sv
// Self-checking bench for dm_sized (WORDS=16, READ_LAT=3).
// Byte-array reference model plus directed literal checks.
module tb_dm_sized;

    localparam int WORDS = 16;
    localparam int RL    = 3;
    localparam int NB    = 4 * WORDS;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        uns = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] pc = '0;
    logic        ready, rvalid, err;
    logic [31:0] rdata;

    int checks = 0;
    int failures = 0;

    dm_sized #(.WORDS(WORDS), .READ_LAT(RL)) dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .we     (we),
        .size   (size),
        .uns    (uns),
        .addr   (addr),
        .wdata  (wdata),
        .pc     (pc),
        .ready  (ready),
        .rvalid (rvalid),
        .rdata  (rdata),
        .err    (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  mbytes [NB];
    bit          started = 0;
    bit          m_ready = 0;
    bit          m_rvalid = 0;
    bit          m_err = 0;
    logic [31:0] m_rdata = '0;
    logic [31:0] m_pdata = '0;
    int          m_clear = 0;
    int          m_pend = 0;

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic bit m_illegal(input logic [1:0] sz,
                                     input logic [31:0] a);
        if (sz == 2'b11) return 1;
        if (a >= NB) return 1;
        return (a % nbytes(sz)) != 0;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] a,
                                           input logic [1:0] sz,
                                           input logic u);
        logic [31:0] v;
        int n;
        v = '0;
        n = nbytes(sz);
        for (int i = 0; i < n; i++)
            v[8*i +: 8] = mbytes[int'(a[5:0]) + i];
        if (!u && n == 1) v = {{24{v[7]}}, v[7:0]};
        if (!u && n == 2) v = {{16{v[15]}}, v[15:0]};
        return v;
    endfunction

    always @(posedge clk) begin
        if (!reset) begin
            started  = 1;
            m_clear  = WORDS;
            m_pend   = 0;
            m_rvalid = 0;
            m_err    = 0;
            m_rdata  = '0;
            for (int i = 0; i < NB; i++) mbytes[i] = 8'h00;
        end else if (started) begin
            m_rvalid = 0;
            m_err    = 0;
            if (m_clear > 0) m_clear--;
            if (m_pend > 0) begin
                m_pend--;
                if (m_pend == 0) begin
                    m_rvalid = 1;
                    m_rdata  = m_pdata;
                end
            end
            if (req && m_ready) begin
                if (m_illegal(size, addr)) begin
                    m_err = 1;
                    if (!we) begin
                        m_rvalid = 1;
                        m_rdata  = '0;
                    end
                end else if (we) begin
                    for (int i = 0; i < nbytes(size); i++)
                        mbytes[int'(addr[5:0]) + i] = wdata[8*i +: 8];
                end else begin
                    m_pdata = m_load(addr, size, uns);
                    m_pend  = RL - 1;
                    if (RL == 1) begin
                        m_rvalid = 1;
                        m_rdata  = m_pdata;
                    end
                end
            end
        end
        m_ready = started && m_clear == 0 && m_pend == 0;
    end

    // every-cycle compare against the model
    always @(negedge clk) begin
        if (started) begin
            chk("cyc_ready", {31'b0, ready}, {31'b0, m_ready});
            chk("cyc_rvalid", {31'b0, rvalid}, {31'b0, m_rvalid});
            chk("cyc_err", {31'b0, err}, {31'b0, m_err});
            chk("cyc_rdata", rdata, m_rdata);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic issue(input logic w, input logic [1:0] sz,
                         input logic u, input logic [31:0] a,
                         input logic [31:0] d);
        int n;
        n = 0;
        while (!m_ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (!m_ready) begin
            checks++;
            failures++;
            $display("FAIL issue_timeout: got busy want ready");
        end
        req = 1'b1; we = w; size = sz; uns = u; addr = a; wdata = d;
        pc = pc + 32'd4;
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic load_chk(input string nm, input logic [1:0] sz,
                            input logic u, input logic [31:0] a,
                            input logic [31:0] exp, input logic exp_err);
        bit seen;
        seen = 0;
        issue(1'b0, sz, u, a, 32'h0);
        for (int i = 0; i < 8; i++) begin
            if (rvalid) begin
                chk(nm, rdata, exp);
                chk({nm, "_err"}, {31'b0, err}, {31'b0, exp_err});
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) chk({nm, "_rvalid_timeout"}, {31'b0, rvalid}, 32'h1);
    endtask

    task automatic clear_count(output int n, output int rv);
        n = 0;
        rv = 0;
        while (!ready && n < 100) begin
            if (rvalid) rv++;
            n++;
            @(negedge clk);
        end
    endtask

    int n, rv, extra;

    initial begin
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", {31'b0, ready}, 32'h0);
        chk("rst_rvalid", {31'b0, rvalid}, 32'h0);
        chk("rst_err", {31'b0, err}, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        reset = 1'b1;
        clear_count(n, rv);
        chk("clear_len", n, 16);
        load_chk("lw_3c", 2'b10, 1'b0, 32'h3C, 32'h0, 1'b0);

        issue(1'b1, 2'b10, 1'b0, 32'h0, 32'h12345678);
        load_chk("lb_1", 2'b00, 1'b0, 32'h1, 32'h00000056, 1'b0);
        load_chk("lbu_3", 2'b00, 1'b1, 32'h3, 32'h00000012, 1'b0);
        load_chk("lh_2", 2'b01, 1'b0, 32'h2, 32'h00001234, 1'b0);
        issue(1'b1, 2'b00, 1'b0, 32'h0, 32'h80);
        load_chk("lb_0", 2'b00, 1'b0, 32'h0, 32'hFFFFFF80, 1'b0);
        load_chk("lbu_0", 2'b00, 1'b1, 32'h0, 32'h00000080, 1'b0);

        issue(1'b1, 2'b10, 1'b0, 32'h4, 32'h11223344);
        issue(1'b1, 2'b00, 1'b0, 32'h5, 32'hAB);
        load_chk("merge_sb", 2'b10, 1'b0, 32'h4, 32'h1122AB44, 1'b0);
        issue(1'b1, 2'b01, 1'b0, 32'h6, 32'hBEEF);
        load_chk("merge_sh", 2'b10, 1'b0, 32'h4, 32'hBEEFAB44, 1'b0);

        issue(1'b1, 2'b10, 1'b0, 32'h6, 32'hFFFFFFFF);
        chk("sw_mis_err", {31'b0, err}, 32'h1);
        load_chk("sw_mis_keep", 2'b10, 1'b0, 32'h4, 32'hBEEFAB44, 1'b0);
        load_chk("lh_mis", 2'b01, 1'b0, 32'h3, 32'h0, 1'b1);
        load_chk("lw_oor", 2'b10, 1'b0, 32'h40, 32'h0, 1'b1);

        issue(1'b1, 2'b10, 1'b0, 32'h8, 32'hCAFEF00D);
        load_chk("b2b_sw_lw", 2'b10, 1'b0, 32'h8, 32'hCAFEF00D, 1'b0);

        req = 1'b1; we = 1'b0; size = 2'b10; uns = 1'b0; addr = 32'h8;
        @(negedge clk);
        addr = 32'h0;
        chk("lat_c1_ready", {31'b0, ready}, 32'h0);
        @(negedge clk);
        req = 1'b0;
        chk("lat_c2_ready", {31'b0, ready}, 32'h0);
        chk("lat_c2_rvalid", {31'b0, rvalid}, 32'h0);
        @(negedge clk);
        chk("lat_c3_ready", {31'b0, ready}, 32'h1);
        chk("lat_c3_rvalid", {31'b0, rvalid}, 32'h1);
        chk("lat_c3_rdata", rdata, 32'hCAFEF00D);
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            if (rvalid) extra++;
        end
        chk("lat_no_dup", extra, 0);

        issue(1'b0, 2'b10, 1'b0, 32'h8, 32'h0);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        clear_count(n, rv);
        chk("wait_rst_rvalid", rv, 0);
        chk("wait_rst_clear", n, 16);
        load_chk("wait_rst_zero", 2'b10, 1'b0, 32'h8, 32'h0, 1'b0);

        issue(1'b1, 2'b10, 1'b0, 32'hC, 32'h55AA55AA);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (7) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        clear_count(n, rv);
        chk("clr7_restart", n, 16);
        load_chk("clr7_zero", 2'b10, 1'b0, 32'hC, 32'h0, 1'b0);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dm_sized.md
Name: dm_sized

Overview:
- Parametrised data memory for the single-cycle/multi-cycle MIPS datapath.
- Successor to the fixed 1024×32 word-only data memory.
- Adds configurable depth, byte/half/word stores and loads with sign/zero extension, and a req/ready/rvalid handshake with configurable read latency.
- Clears its array one word per cycle after reset, and flags misaligned or out-of-range accesses.

Parameters:
- WORDS, 1024, number of 32-bit words; power of two, ≥4.
- READ_LAT, 1, cycles from load acceptance edge to rvalid; range 1..4.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  synchronous, active-low reset.
- req  in  1  access request.
- we  in  1  1 = store, 0 = load; sampled with req.
- size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- uns  in  1  load zero-extends when 1, sign-extends when 0.
- addr  in  32  byte address.
- wdata  in  32  store data, right-justified.
- pc  in  32  PC of the issuing instruction; used only for trace.
- ready  out  1  block can accept req this cycle.
- rvalid  out  1  one-cycle pulse; rdata valid.
- rdata  out  32  extended load result; holds its value between pulses.
- err  out  1  one-cycle pulse, cycle after an illegal access is accepted.

Behaviour:
- States: CLEAR, IDLE, WAIT.
- Reset (reset==0 at an edge):
  - state←CLEAR, clr_idx←0.
  - ready=0, rvalid=0, err=0, rdata=0.
  - Any in-flight load is dropped with no rvalid.
  - Reset mid-CLEAR restarts clearing at index 0.
- CLEAR:
  - Each cycle writes 0 to mem[clr_idx] and increments clr_idx.
  - After writing index WORDS-1 → IDLE.
  - ready=0 for exactly WORDS cycles after reset deasserts.
- Acceptance: req && ready at a rising edge. Requests while ready=0 are ignored, not queued.
- Illegal access, any of:
  - size==11;
  - half with addr[0]=1;
  - word with addr[1:0]≠0;
  - addr ≥ 4·WORDS.
  - Response: no memory change; err=1 in the next cycle.
  - If it is a load: rvalid=1 and rdata=0 in that same cycle.
  - state stays IDLE; ready stays 1.
- Store (IDLE):
  - Commits at the acceptance edge; state stays IDLE, ready stays 1, so back-to-back stores are allowed.
  - Little-endian lanes.
  - sb: wdata[7:0] → lane addr[1:0].
  - sh: wdata[15:0] → lanes {addr[1],0} and {addr[1],1}.
  - sw: whole word.
  - Other lanes are preserved.
- Load (IDLE):
  - Latches the word index, byte offset, size and uns; → WAIT with cnt=READ_LAT-1; ready=0.
  - When cnt reaches 0, the word is read, formatted and registered into rdata; rvalid=1 in the following cycle.
  - State returns to IDLE with ready=1 in that same cycle, so a new req is accepted in the rvalid cycle.
  - Total: rvalid asserts READ_LAT cycles after the acceptance edge.
- Formatting:
  - lb/lbu: selected byte, sign- or zero-extended to 32.
  - lh/lhu: selected half, sign- or zero-extended.
  - lw: word as stored.
- A store accepted in cycle t is visible to a load accepted in cycle t+1.
- Index used: addr[log2(WORDS)+1:2].

Optional Feature:
- Macro: DM_TRACE_EN.
- Defined: each committed store prints "@%h: *%h <= %h" with pc, addr with low 2 bits cleared, and the full merged 32-bit word after the write. Illegal accesses print nothing.
- Undefined: no simulation output; RTL otherwise identical.

Decomposition:
- Package dm_pkg holds:
  - size encodings SZ_B=2'b00, SZ_H=2'b01, SZ_W=2'b10;
  - state encoding CLEAR/IDLE/WAIT;
  - helper function computing the illegal-access flag.
- One combinational sub-module, dm_lane_fmt:
  - store-side byte-lane merge (old word, wdata, offset, size → new word);
  - load-side extract/extend (word, offset, size, uns → rdata).
- The FSM, counters and array stay in dm_sized.

Test Plan (bench uses WORDS=16 unless noted):
- Reset: hold reset=0 for 2 cycles, release → ready=0 for exactly 16 cycles, then 1; lw 0x3C → rvalid with rdata=0x00000000.
- Sub-word loads: sw 0x0 0x12345678 →
  - lb 0x1 → 0x00000056;
  - lbu 0x3 → 0x00000012;
  - lh 0x2 → 0x00001234.
  - Then sb 0x0 0x80; lb 0x0 → 0xFFFFFF80; lbu 0x0 → 0x00000080.
- Lane merge: sw 0x4 0x11223344; sb 0x5 0xAB → lw 0x4 = 0x1122AB44. sh 0x6 0xBEEF → 0xBEEFAB44.
- Illegal accesses:
  - sw 0x6 0xFFFFFFFF → err pulse, word 0x4 unchanged.
  - lh 0x3 → err=1, rvalid=1, rdata=0.
  - lw 0x40 (out of range) → err=1.
- Latency (READ_LAT=3): lw accepted at edge t → ready=0 in the 2 cycles after t; rvalid=1 and ready=1 in the 3rd cycle after t. A req during the busy cycles is ignored (no second rvalid). A back-to-back store then load to the same word returns the new data.
- Reset mid-operation:
  - reset=0 during WAIT → no rvalid, and a full 16-cycle CLEAR follows.
  - reset=0 at clr_idx=7 → clearing restarts at index 0 (ready low for 16 more cycles).
